// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: MAR/MDR on the shared main_bus plus the req/ack
// memory sequencer that produces the R (ready) handshake and a watchdog.
//
// state | meaning
// IDLE  | no transaction; MIO_EN starts a request
// WAIT  | mem_req asserted, waiting for mem_ack or watchdog expiry
// DONE  | transaction complete, R held until MIO_EN drops
module lc3_mem_if #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire  [15:0] main_bus,
   input  logic        LDMAR,
   input  logic        LDMDR,
   input  logic        GateMDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   output logic        R,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A zero TIMEOUT_CYC wraps this to 16'hFFFF, but the enable term below masks it.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      r_state;
   logic [15:0] r_mar;
   logic [15:0] r_mdr;
   logic [15:0] r_rbuf;
   logic [15:0] r_wd_cnt;
   logic        w_wd_expire;

   assign w_wd_expire = (TIMEOUT_CYC != 0) && (r_wd_cnt == WD_LAST);

   assign main_bus  = GateMDR ? r_mdr : 16'hzzzz;
   assign mem_addr  = r_mar;
   assign mem_wdata = r_mdr;

   // Access sequencer: request, wait for ack or watchdog, then hold R until MIO_EN drops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         R        <= 1'b0;
         bus_err  <= 1'b0;
         r_wd_cnt <= 16'h0000;
         r_rbuf   <= 16'h0000;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (MIO_EN) begin
                  r_state  <= ST_WAIT;
                  mem_req  <= 1'b1;
                  mem_we   <= R_W;
                  r_wd_cnt <= 16'h0000;
               end
            end
            ST_WAIT: begin
               // Ack takes priority over a watchdog expiry on the same edge.
               if (mem_ack) begin
                  r_state <= ST_DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  R       <= 1'b1;
                  if (!mem_we) r_rbuf <= mem_rdata;
               end else if (w_wd_expire) begin
                  r_state <= ST_DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  R       <= 1'b1;
                  r_rbuf  <= 16'h0000;
                  bus_err <= 1'b1;
               end else if (r_wd_cnt != 16'hFFFF) begin
                  r_wd_cnt <= r_wd_cnt + 16'd1;
               end
            end
            ST_DONE: begin
               if (!MIO_EN) begin
                  r_state <= ST_IDLE;
                  R       <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // MAR/MDR loads; both are frozen while a request is outstanding.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mar <= 16'h0000;
         r_mdr <= 16'h0000;
      end else if (r_state != ST_WAIT) begin
         if (LDMAR) r_mar <= main_bus;
         if (LDMDR) begin
            if (!MIO_EN)                r_mdr <= main_bus;
            else if (r_state == ST_DONE) r_mdr <= r_rbuf;
         end
      end
   end

endmodule
